// File: rtl/als_sample_scheduler.sv
// Pmod ALS (ADC081S021) transaction scheduler: generates CS/SCK, shifts in a 16-bit frame,
// and arbitrates periodic ticks against on-demand requests with a single pending slot.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | cs=1, sck=1, waiting for tick/request/pending start
// SETUP | cs=0, sck=1 for CLK_DIV cycles before the first fall
// LOW   | sck=0 for CLK_DIV cycles; sdo settles
// HIGH  | sck=1 for CLK_DIV cycles; sdo sampled on entry
// QUIET | cs=1, busy=1 for QUIET cycles of CS-high gap
module als_sample_scheduler #(
  parameter int CLK_DIV       = 3,
  parameter int SAMPLE_PERIOD = 1200000,
  parameter int QUIET         = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        request,
  input  logic        sdo,
  output logic        cs,
  output logic        sck,
  output logic        busy,
  output logic        valid,
  output logic [15:0] value,
  output logic [7:0]  light,
  output logic        missed
);

  localparam int PERIOD_W  = $clog2(SAMPLE_PERIOD);
  localparam int TIMER_MAX = (CLK_DIV > QUIET) ? CLK_DIV : QUIET;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(SAMPLE_PERIOD - 1);
  localparam logic [TIMER_W-1:0]  DIV_LOAD    = TIMER_W'(CLK_DIV - 1);
  localparam logic [TIMER_W-1:0]  QUIET_LOAD  = TIMER_W'(QUIET - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_QUIET
  } state_t;

  state_t              state, state_nxt;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic [3:0]          bit_cnt, bit_cnt_nxt;
  logic                pending, pending_nxt;
  logic [15:0]         shift;
  logic [PERIOD_W-1:0] period_cnt;
  logic                tick;
  logic                src;
  logic                timer_done;
  logic                sample_edge;
  logic                frame_done;

  // Free-running period counter; never stalled by transactions or enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (period_cnt == PERIOD_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PERIOD_W'(1);
    end
  end

  assign tick       = (period_cnt == PERIOD_LAST) & enable;
  assign src        = tick | request;
  assign timer_done = (timer == '0);

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer_done ? timer : timer - TIMER_W'(1);
    bit_cnt_nxt = bit_cnt;
    pending_nxt = pending;
    missed      = 1'b0;
    sample_edge = 1'b0;
    frame_done  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (src | pending) begin
          state_nxt   = ST_SETUP;
          timer_nxt   = DIV_LOAD;
          bit_cnt_nxt = 4'd15;
          pending_nxt = 1'b0;
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          state_nxt = ST_LOW;
          timer_nxt = DIV_LOAD;
        end
      end
      ST_LOW: begin
        if (timer_done) begin
          state_nxt   = ST_HIGH;
          timer_nxt   = DIV_LOAD;
          sample_edge = 1'b1;
        end
      end
      ST_HIGH: begin
        if (timer_done) begin
          if (bit_cnt == 4'd0) begin
            state_nxt  = ST_QUIET;
            timer_nxt  = QUIET_LOAD;
            frame_done = 1'b1;
          end else begin
            state_nxt   = ST_LOW;
            timer_nxt   = DIV_LOAD;
            bit_cnt_nxt = bit_cnt - 4'd1;
          end
        end
      end
      ST_QUIET: begin
        if (timer_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Starts arriving mid-transaction collapse into one pending slot.
    if ((state != ST_IDLE) && src) begin
      pending_nxt = 1'b1;
      missed      = pending;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      pending <= 1'b0;
      shift   <= '0;
      value   <= '0;
      light   <= '0;
      valid   <= 1'b0;
      cs      <= 1'b1;
      sck     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_cnt <= bit_cnt_nxt;
      pending <= pending_nxt;
      valid   <= frame_done;
      if (sample_edge) begin
        shift <= {shift[14:0], sdo};
      end
      if (frame_done) begin
        value <= shift;
        light <= shift[12:5];
      end
      cs   <= (state_nxt == ST_IDLE) || (state_nxt == ST_QUIET);
      sck  <= (state_nxt != ST_LOW);
      busy <= (state_nxt != ST_IDLE);
    end
  end

endmodule
